uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_if.sv | 32 +++
 rtl/uart_rx_fifo.sv | 61 ++++++
 tb/tb_uart_rx_fifo.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-to-consumer FIFO bus.
//   i_data/i_data_valid : byte and write strobe from the UART receiver
//   i_rd_en             : consumer pop request
//   i_clr_overrun       : clears the sticky overrun flag
//   o_data              : head entry (first-word-fall-through)
//   o_empty/o_full      : occupancy is zero / DEPTH
//   o_count             : current occupancy
//   o_thresh            : o_count >= THRESH
//   o_overrun           : sticky, a byte was dropped
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
);
    logic [DATA_BITS-1:0]   i_data;
    logic                   i_data_valid;
    logic                   i_rd_en;
    logic                   i_clr_overrun;
    logic [DATA_BITS-1:0]   o_data;
    logic                   o_empty;
    logic                   o_full;
    logic [$clog2(DEPTH):0] o_count;
    logic                   o_thresh;
    logic                   o_overrun;
    modport master (
        output i_data, i_data_valid, i_rd_en, i_clr_overrun,
        input  o_data, o_empty, o_full, o_count, o_thresh, o_overrun
    );
    modport slave (
        input  i_data, i_data_valid, i_rd_en, i_clr_overrun,
        output o_data, o_empty, o_full, o_count, o_thresh, o_overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive FIFO with threshold and sticky overrun flags.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset (control state only, RAM unreset)
//   bus : uart_rx_fifo_if.slave, data/strobe in, head/status out
module uart_rx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int THRESH    = 8
) (
    input logic           clk,
    input logic           rst,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;
    logic [DATA_BITS-1:0] r_last;
    logic                 r_overrun;
    logic                 r_arm;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_drop;
    assign w_empty = r_count == '0;
    assign w_full  = r_count == (AW+1)'(DEPTH);
    // r_arm blocks both operations on the first edge after reset release.
    // A write while full is accepted only when a pop frees the slot that cycle.
    assign w_rd    = r_arm && bus.i_rd_en && !w_empty;
    assign w_wr    = r_arm && bus.i_data_valid && (!w_full || bus.i_rd_en);
    assign w_drop  = r_arm && bus.i_data_valid && w_full && !bus.i_rd_en;
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= bus.i_data;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_last    <= '0;
            r_overrun <= 1'b0;
            r_arm     <= 1'b0;
        end else begin
            r_arm     <= 1'b1;
            r_wr_ptr  <= w_wr ? r_wr_ptr + AW'(1) : r_wr_ptr;
            r_rd_ptr  <= w_rd ? r_rd_ptr + AW'(1) : r_rd_ptr;
            r_count   <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
            // Hold the last popped head so o_data stays stable once empty.
            r_last    <= w_rd ? r_mem[r_rd_ptr] : r_last;
            r_overrun <= w_drop ? 1'b1 : bus.i_clr_overrun ? 1'b0 : r_overrun;
        end
    end
    assign bus.o_data    = w_empty ? r_last : r_mem[r_rd_ptr];
    assign bus.o_empty   = w_empty;
    assign bus.o_full    = w_full;
    assign bus.o_count   = r_count;
    assign bus.o_thresh  = r_count >= (AW+1)'(THRESH);
    assign bus.o_overrun = r_overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed table and sequence checks for uart_rx_fifo.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] q[$];
    logic [7:0] last;
    logic       m_ovr;
    uart_rx_fifo_if #(.DATA_BITS(8), .DEPTH(16)) bus();
    uart_rx_fifo #(.DATA_BITS(8), .DEPTH(16), .THRESH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct {
        string      name;
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       c;
        int         cnt;
        logic [7:0] dat;
        logic       emp;
        logic       ful;
        logic       thr;
        logic       ovr;
    } vec_t;
    vec_t tbl[8];
    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
        @(negedge clk);
        bus.i_data_valid  = v;
        bus.i_data        = d;
        bus.i_rd_en       = r;
        bus.i_clr_overrun = c;
        @(posedge clk);
        #1;
        bus.i_data_valid  = 1'b0;
        bus.i_rd_en       = 1'b0;
        bus.i_clr_overrun = 1'b0;
    endtask
    task automatic exp_st(input string n, input int cnt, input logic [7:0] dat, input logic ovr);
        chk({n, ".count"},   int'(bus.o_count),   cnt);
        chk({n, ".data"},    int'(bus.o_data),    int'(dat));
        chk({n, ".empty"},   int'(bus.o_empty),   int'(cnt == 0));
        chk({n, ".full"},    int'(bus.o_full),    int'(cnt == 16));
        chk({n, ".thresh"},  int'(bus.o_thresh),  int'(cnt >= 8));
        chk({n, ".overrun"}, int'(bus.o_overrun), int'(ovr));
    endtask
    // Reference queue: pop first (only if non-empty), then write if not full or a pop freed room.
    task automatic mstep(input string n, input logic v, input logic [7:0] d, input logic r, input logic c);
        bit was_full;
        was_full = q.size() == 16;
        if (r && q.size() != 0) last = q.pop_front();
        if (v && (!was_full || r)) q.push_back(d);
        if (v && was_full && !r) m_ovr = 1'b1;
        else if (c) m_ovr = 1'b0;
        step(v, d, r, c);
        exp_st(n, q.size(), q.size() != 0 ? q[0] : last, m_ovr);
    endtask
    initial begin
        bus.i_data = '0;
        bus.i_data_valid = 1'b0;
        bus.i_rd_en = 1'b0;
        bus.i_clr_overrun = 1'b0;
        tbl[0] = '{"wr_a5",     1'b1, 8'hA5, 1'b0, 1'b0, 1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{"wr_5a",     1'b1, 8'h5A, 1'b0, 1'b0, 2, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{"pop1",      1'b0, 8'h00, 1'b1, 1'b0, 1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{"pop2",      1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{"pop_empty", 1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{"wr_rd_emp", 1'b1, 8'h3C, 1'b1, 1'b0, 1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{"pop3",      1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{"clr_idle",  1'b0, 8'h00, 1'b0, 1'b1, 0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0};
        #1;
        exp_st("reset", 0, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        bus.i_data_valid = 1'b1;
        bus.i_data = 8'hEE;
        @(posedge clk);
        #1;
        bus.i_data_valid = 1'b0;
        chk("first_edge.count", int'(bus.o_count), 0);
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].c);
            chk({tbl[i].name, ".count"},   int'(bus.o_count),   tbl[i].cnt);
            chk({tbl[i].name, ".data"},    int'(bus.o_data),    int'(tbl[i].dat));
            chk({tbl[i].name, ".empty"},   int'(bus.o_empty),   int'(tbl[i].emp));
            chk({tbl[i].name, ".full"},    int'(bus.o_full),    int'(tbl[i].ful));
            chk({tbl[i].name, ".thresh"},  int'(bus.o_thresh),  int'(tbl[i].thr));
            chk({tbl[i].name, ".overrun"}, int'(bus.o_overrun), int'(tbl[i].ovr));
        end
        last  = 8'h3C;
        m_ovr = 1'b0;
        for (int i = 0; i < 16; i++) mstep("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        mstep("drop_ff", 1'b1, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) mstep("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        mstep("clr", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) mstep("refill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        mstep("full_wr_rd", 1'b1, 8'h77, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) mstep("drain77", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) mstep("pre_wrap", 1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) mstep("wrap_pair", 1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) mstep("post_wrap", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) mstep("fill2", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        mstep("clr_and_drop", 1'b1, 8'hEE, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) mstep("to_five", 1'b0, 8'h00, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        exp_st("async_rst", 0, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        bus.i_data_valid = 1'b1;
        bus.i_data = 8'h99;
        @(posedge clk);
        #1;
        chk("rel_edge.count", int'(bus.o_count), 0);
        @(posedge clk);
        #1;
        bus.i_data_valid = 1'b0;
        exp_st("after_rel", 1, 8'h99, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
